// File: rtl/cc_param_reorder_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : cc_param_reorder_unit                                           |
// | Purpose  : Merges memory miss bursts and buffered hit lines onto one R     |
// |            channel in flag-push order, critical word first for hits.       |
// | Option   : CC_REORDER_OUTREG_EN adds a 2-entry skid register on inct_*.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module cc_param_reorder_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4,
   parameter int AFULL = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_empty,
   output logic         o_afull
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_pop;
   logic          w_push;

   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign w_pop  = i_pop && (r_cnt != '0);
   assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
         if (w_pop)  r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
         if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
         else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rp];
   assign o_empty = (r_cnt == '0);
   assign o_afull = (r_cnt >= CW'(AFULL));
endmodule

module cc_param_reorder_unit #(
   parameter  int DATA_W     = 64,
   parameter  int BURST_LEN  = 8,
   parameter  int FLAG_DEPTH = 4,
   parameter  int FLAG_AFULL = 2,
   parameter  int HIT_DEPTH  = 2,
   parameter  int HIT_AFULL  = 1,
   localparam int OFS_W      = $clog2(BURST_LEN),
   localparam int LINE_W     = BURST_LEN * DATA_W,
   localparam int HIT_W      = OFS_W + LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_rlast_i,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o,
   input  logic              flag_wren_i,
   input  logic              flag_wdata_i,
   output logic              flag_afull_o,
   input  logic              hit_wren_i,
   input  logic [HIT_W-1:0]  hit_wdata_i,
   output logic              hit_afull_o,
   output logic [DATA_W-1:0] inct_rdata_o,
   output logic              inct_rlast_o,
   output logic              inct_rvalid_o,
   input  logic              inct_rready_i,
   output logic              proto_err_o
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MISS = 2'd1,
      S_HIT  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [OFS_W-1:0]   r_cnt;
   logic               r_perr;
   logic               w_flag_empty;
   logic               w_flag_head;
   logic               w_flag_pop;
   logic               w_hit_empty;
   logic [HIT_W-1:0]   w_hit_head;
   logic               w_hit_pop;
   logic [OFS_W-1:0]   w_hit_idx;
   logic [LINE_W-1:0]  w_hit_line;
   logic               w_last;
   logic               w_fire;
   logic               w_core_valid;
   logic [DATA_W-1:0]  w_core_data;
   logic               w_core_last;
   logic               w_core_ready;

   cc_param_reorder_fifo #(.W(1), .DEPTH(FLAG_DEPTH), .AFULL(FLAG_AFULL)) u_flag_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(flag_wren_i), .i_wdata(flag_wdata_i),
      .i_pop(w_flag_pop), .o_rdata(w_flag_head), .o_empty(w_flag_empty), .o_afull(flag_afull_o)
   );

   cc_param_reorder_fifo #(.W(HIT_W), .DEPTH(HIT_DEPTH), .AFULL(HIT_AFULL)) u_hit_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(hit_wren_i), .i_wdata(hit_wdata_i),
      .i_pop(w_hit_pop), .o_rdata(w_hit_head), .o_empty(w_hit_empty), .o_afull(hit_afull_o)
   );

   // OFS_W-bit addition wraps modulo BURST_LEN for critical-word-first order.
   assign w_hit_idx  = w_hit_head[HIT_W-1 -: OFS_W] + r_cnt;
   assign w_hit_line = w_hit_head[LINE_W-1:0];
   assign w_last     = (r_cnt == OFS_W'(BURST_LEN - 1));

   always_comb begin
      w_next       = r_state;
      w_flag_pop   = 1'b0;
      w_hit_pop    = 1'b0;
      w_fire       = 1'b0;
      w_core_valid = 1'b0;
      w_core_data  = '0;
      w_core_last  = 1'b0;
      mem_rready_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_flag_empty && (!w_flag_head || !w_hit_empty)) begin
               w_flag_pop = 1'b1;
               w_next     = w_flag_head ? S_HIT : S_MISS;
            end
         end
         S_MISS: begin
            w_core_valid = mem_rvalid_i;
            w_core_data  = mem_rdata_i;
            w_core_last  = w_last;
            mem_rready_o = w_core_ready;
            w_fire       = mem_rvalid_i && w_core_ready;
            if (w_fire && w_last) w_next = S_IDLE;
         end
         S_HIT: begin
            w_core_valid = 1'b1;
            w_core_data  = w_hit_line[w_hit_idx * DATA_W +: DATA_W];
            w_core_last  = w_last;
            w_fire       = w_core_ready;
            if (w_fire && w_last) begin
               w_hit_pop = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) r_cnt <= '0;
         else if (w_fire)       r_cnt <= r_cnt + 1'b1;
         if ((r_state == S_MISS) && w_fire && (mem_rlast_i != w_last)) r_perr <= 1'b1;
      end
   end

   assign proto_err_o = r_perr;

`ifdef CC_REORDER_OUTREG_EN
   logic [DATA_W-1:0] r_sk_data [2];
   logic              r_sk_last [2];
   logic              r_sk_wp;
   logic              r_sk_rp;
   logic [1:0]        r_sk_cnt;
   logic              w_sk_pop;

   // Ready comes from registered occupancy, breaking every path to the outputs.
   assign w_core_ready = (r_sk_cnt != 2'd2);
   assign w_sk_pop     = inct_rvalid_o && inct_rready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sk_wp  <= 1'b0;
         r_sk_rp  <= 1'b0;
         r_sk_cnt <= 2'd0;
      end else begin
         if (w_fire)   r_sk_wp <= ~r_sk_wp;
         if (w_sk_pop) r_sk_rp <= ~r_sk_rp;
         if (w_fire && !w_sk_pop)      r_sk_cnt <= r_sk_cnt + 2'd1;
         else if (w_sk_pop && !w_fire) r_sk_cnt <= r_sk_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fire) begin
         r_sk_data[r_sk_wp] <= w_core_data;
         r_sk_last[r_sk_wp] <= w_core_last;
      end
   end

   assign inct_rvalid_o = (r_sk_cnt != 2'd0);
   assign inct_rdata_o  = r_sk_data[r_sk_rp];
   assign inct_rlast_o  = inct_rvalid_o && r_sk_last[r_sk_rp];
`else
   assign w_core_ready  = inct_rready_i;
   assign inct_rvalid_o = w_core_valid;
   assign inct_rdata_o  = w_core_data;
   assign inct_rlast_o  = w_core_last;
`endif
endmodule

`default_nettype wire

// File: tb/tb_cc_param_reorder_unit.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_cc_param_reorder_unit                                        |
// | Purpose  : Directed, table-driven bench for cc_param_reorder_unit.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cc_param_reorder_unit;
   localparam int DATA_W = 64;
   localparam int BL     = 8;
   localparam int OFS_W  = 3;
   localparam int HW     = OFS_W + BL * DATA_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] mem_rdata_i = '0;
   logic              mem_rlast_i = 1'b0;
   logic              mem_rvalid_i = 1'b0;
   logic              mem_rready_o;
   logic              flag_wren_i = 1'b0;
   logic              flag_wdata_i = 1'b0;
   logic              flag_afull_o;
   logic              hit_wren_i = 1'b0;
   logic [HW-1:0]     hit_wdata_i = '0;
   logic              hit_afull_o;
   logic [DATA_W-1:0] inct_rdata_o;
   logic              inct_rlast_o;
   logic              inct_rvalid_o;
   logic              inct_rready_i = 1'b1;
   logic              proto_err_o;

   cc_param_reorder_unit dut (
      .clk(clk), .rst_n(rst_n),
      .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rready_o(mem_rready_o),
      .flag_wren_i(flag_wren_i), .flag_wdata_i(flag_wdata_i), .flag_afull_o(flag_afull_o),
      .hit_wren_i(hit_wren_i), .hit_wdata_i(hit_wdata_i), .hit_afull_o(hit_afull_o),
      .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o),
      .inct_rready_i(inct_rready_i), .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {logic [63:0] data; logic last;} beat_t;
   typedef struct {logic [63:0] data; logic last; logic perr;} obs_t;
   typedef struct {bit hit; logic [2:0] ofs; logic [63:0] base;} burst_t;

   beat_t mem_q[$];
   obs_t  got[$];
   int    errors = 0;
   int    checks = 0;
   int    rr_mode = 0;
   bit    rr_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory R-channel model: a beat leaves the queue only after a handshake.
   initial begin
      bit fire;
      forever begin
         @(negedge clk);
         fire = mem_rvalid_i && mem_rready_o;
         @(posedge clk);
         #1;
         if (fire && mem_q.size() != 0) void'(mem_q.pop_front());
         mem_rvalid_i = (mem_q.size() != 0);
         mem_rdata_i  = (mem_q.size() != 0) ? mem_q[0].data : '0;
         mem_rlast_i  = (mem_q.size() != 0) ? mem_q[0].last : 1'b0;
      end
   end

   initial begin
      int idx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rr_mode == 0) inct_rready_i = 1'b1;
         else begin
            inct_rready_i = rr_pat[idx % 4];
            idx++;
         end
      end
   end

   // Output collector; also verifies data/last hold during back-pressure.
   initial begin
      bit          stall = 1'b0;
      logic [63:0] pd = '0;
      logic        pl = 1'b0;
      forever begin
         @(negedge clk);
         if (stall && rst_n) begin
            check("hold_valid", 64'(inct_rvalid_o), 64'd1);
            check("hold_data", inct_rdata_o, pd);
            check("hold_last", 64'(inct_rlast_o), 64'(pl));
         end
         if (inct_rvalid_o && inct_rready_i)
            got.push_back('{inct_rdata_o, inct_rlast_o, proto_err_o});
         stall = rst_n && inct_rvalid_o && !inct_rready_i;
         pd    = inct_rdata_o;
         pl    = inct_rlast_o;
      end
   end

   task automatic push_flag(input bit v);
      flag_wren_i  = 1'b1;
      flag_wdata_i = v;
      @(posedge clk);
      #1;
      flag_wren_i  = 1'b0;
   endtask

   task automatic push_line(input logic [2:0] ofs, input logic [63:0] base);
      logic [HW-1:0] v;
      v = '0;
      v[HW-1 -: OFS_W] = ofs;
      for (int k = 0; k < BL; k++) v[k*DATA_W +: DATA_W] = base + 64'(k);
      hit_wren_i  = 1'b1;
      hit_wdata_i = v;
      @(posedge clk);
      #1;
      hit_wren_i  = 1'b0;
   endtask

   task automatic load_miss(input logic [63:0] base, input int extra_last);
      for (int k = 0; k < BL; k++)
         mem_q.push_back('{base + 64'(k), (k == BL - 1) || (k == extra_last)});
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int c = 0; c < budget && got.size() < n; c++) @(posedge clk);
      #1;
      check("beat_count", 64'(got.size()), 64'(n));
   endtask

   initial begin
      burst_t tbl[4];
      beat_t  exp_q[$];

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rvalid", 64'(inct_rvalid_o), 64'd0);
      check("rst_rlast", 64'(inct_rlast_o), 64'd0);
      check("rst_mem_rready", 64'(mem_rready_o), 64'd0);
      check("rst_flag_afull", 64'(flag_afull_o), 64'd0);
      check("rst_hit_afull", 64'(hit_afull_o), 64'd0);
      check("rst_proto_err", 64'(proto_err_o), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mixed miss/hit ordering, including a wrapped hit line
      tbl[0] = '{1'b0, 3'd0, 64'hA0};
      tbl[1] = '{1'b1, 3'd0, 64'h10};
      tbl[2] = '{1'b0, 3'd0, 64'hB0};
      tbl[3] = '{1'b1, 3'd5, 64'h20};
      for (int i = 0; i < 4; i++) begin
         if (tbl[i].hit) push_line(tbl[i].ofs, tbl[i].base);
         else            load_miss(tbl[i].base, -1);
         for (int k = 0; k < BL; k++)
            exp_q.push_back('{tbl[i].hit ? tbl[i].base + 64'((int'(tbl[i].ofs) + k) % BL)
                                         : tbl[i].base + 64'(k), k == BL - 1});
      end
      for (int i = 0; i < 4; i++) push_flag(tbl[i].hit);
      wait_beats(32, 400);
      for (int i = 0; i < 32 && i < got.size(); i++) begin
         checks++;
         if (got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL order_beat%0d: got %0h/%0b expected %0h/%0b",
                     i, got[i].data, got[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
      repeat (20) @(posedge clk);
      #1;
      check("order_no_extra", 64'(got.size()), 64'd32);
      check("order_proto_err", 64'(proto_err_o), 64'd0);
      got.delete();

      // Hit burst under ready pattern 1,0,0,1
      rr_mode = 1;
      push_line(3'd2, 64'h40);
      push_flag(1'b1);
      wait_beats(8, 200);
      for (int k = 0; k < 8 && k < got.size(); k++) begin
         check("stall_data", got[k].data, 64'h40 + 64'((k + 2) % 8));
         check("stall_last", 64'(got[k].last), 64'(k == 7));
      end
      rr_mode = 0;
      repeat (20) @(posedge clk);
      #1;
      check("stall_no_extra", 64'(got.size()), 64'd8);
      got.delete();

      // Early mem_rlast on beat 5
      load_miss(64'hD0, 5);
      push_flag(1'b0);
      wait_beats(8, 200);
      for (int k = 0; k < 8 && k < got.size(); k++)
         check("perr_last", 64'(got[k].last), 64'(k == 7));
      if (got.size() >= 7) begin
         check("perr_before", 64'(got[5].perr), 64'd0);
         check("perr_after", 64'(got[6].perr), 64'd1);
      end
      repeat (10) @(posedge clk);
      #1;
      check("perr_sticky", 64'(proto_err_o), 64'd1);
      rst_n = 1'b0;
      #1;
      check("perr_reset", 64'(proto_err_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      @(posedge clk);
      #1;

      // Flag FIFO fill, almost-full and overflow
      for (int i = 0; i < 4; i++) begin
         push_flag(1'b1);
         check("flag_afull", 64'(flag_afull_o), 64'(i >= 1));
      end
      push_flag(1'b0);
      check("flag_afull_full", 64'(flag_afull_o), 64'd1);
      load_miss(64'hE0, -1);
      check("hit_afull_empty", 64'(hit_afull_o), 64'd0);
      push_line(3'd0, 64'h50);
      check("hit_afull_one", 64'(hit_afull_o), 64'd1);
      push_line(3'd0, 64'h60);
      wait_beats(8, 200);
      push_line(3'd0, 64'h70);
      wait_beats(16, 200);
      push_line(3'd0, 64'h80);
      wait_beats(32, 200);
      repeat (30) @(posedge clk);
      #1;
      check("ovf_beats", 64'(got.size()), 64'd32);
      check("ovf_mem_untouched", 64'(mem_q.size()), 64'd8);
      for (int j = 0; j < 4; j++)
         if (got.size() > 8*j + 7)
            check("ovf_burst_last", got[8*j+7].data, 64'h57 + 64'(16*j));

      // Reset in the middle of a miss burst with flags queued
      mem_q.delete();
      got.delete();
      load_miss(64'hF0, -1);
      push_flag(1'b0);
      push_flag(1'b0);
      push_flag(1'b0);
      for (int c = 0; c < 200 && got.size() < 3; c++) @(posedge clk);
      #2;
      check("mid_rvalid", 64'(inct_rvalid_o), 64'd1);
      check("mid_flag_afull", 64'(flag_afull_o), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rvalid", 64'(inct_rvalid_o), 64'd0);
      check("async_rlast", 64'(inct_rlast_o), 64'd0);
      check("async_mem_rready", 64'(mem_rready_o), 64'd0);
      check("async_flag_afull", 64'(flag_afull_o), 64'd0);
      check("async_hit_afull", 64'(hit_afull_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      repeat (30) @(posedge clk);
      #1;
      check("post_rst_no_beats", 64'(got.size()), 64'd0);
      check("post_rst_mem_rready", 64'(mem_rready_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

`default_nettype wire

// File: doc/cc_param_reorder_unit.md
CC_PARAM_REORDER_UNIT -- requirements
Module: cc_param_reorder_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W  64  beat width in bits
  BURST_LEN  8  beats per burst, power of two, >=2
  FLAG_DEPTH  4  hit-flag FIFO entries
  FLAG_AFULL  2  flag FIFO occupancy at which flag_afull_o asserts
  HIT_DEPTH  2  hit-line FIFO entries
  HIT_AFULL  1  hit-line FIFO occupancy at which hit_afull_o asserts
  OFS_W = log2(BURST_LEN), derived, not overridable.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  mem_rdata_i  in  DATA_W  miss-burst data from memory R channel
  mem_rlast_i  in  1  memory rlast
  mem_rvalid_i  in  1  memory rvalid
  mem_rready_o  out  1  memory rready
  flag_wren_i  in  1  push request flag
  flag_wdata_i  in  1  1 = hit, 0 = miss
  flag_afull_o  out  1  flag FIFO almost full
  hit_wren_i  in  1  push hit line
  hit_wdata_i  in  OFS_W+BURST_LEN*DATA_W  {start offset, line}; word k at bits [k*DATA_W +: DATA_W]
  hit_afull_o  out  1  hit FIFO almost full
  inct_rdata_o  out  DATA_W  R data to interconnect
  inct_rlast_o  out  1  R last
  inct_rvalid_o  out  1  R valid
  inct_rready_i  in  1  R ready
  proto_err_o  out  1  sticky memory-burst length error

Function
REQ-003 Bursts SHALL leave on inct in the exact order of flag pushes, regardless of hit/miss mix.
REQ-004 FSM states SHALL be IDLE, MISS, HIT.
REQ-005 IDLE: pop flag when flag FIFO non-empty and (flag==0, or hit FIFO non-empty); go to MISS (flag 0) or HIT (flag 1) next cycle; otherwise stay.
REQ-006 IDLE SHALL drive inct_rvalid_o=0 and mem_rready_o=0; one bubble cycle between consecutive bursts.
REQ-007 MISS: inct_rdata_o=mem_rdata_i, inct_rvalid_o=mem_rvalid_i, mem_rready_o=inct_rready_i (combinational pass-through).
REQ-008 HIT: inct_rvalid_o=1; inct_rdata_o = word ((ofs+cnt) mod BURST_LEN) of hit FIFO head (critical-word-first wrap).
REQ-009 Beat counter cnt (OFS_W bits) SHALL reset to 0 on entry to MISS/HIT and increment only on inct_rvalid_o&&inct_rready_i.
REQ-010 inct_rlast_o SHALL be asserted iff state!=IDLE and cnt==BURST_LEN-1; it is generated locally, not copied from mem_rlast_i.
REQ-011 On the last-beat handshake: go to IDLE; in HIT also pop hit FIFO in the same cycle.
REQ-012 While inct_rvalid_o=1 and inct_rready_i=0, inct data/last SHALL stay stable (cnt frozen).
REQ-013 proto_err_o SHALL set on a MISS handshake where mem_rlast_i != (cnt==BURST_LEN-1), and clear only on reset.
REQ-014 FIFOs: push when full is ignored (no overwrite); push and pop on the same cycle SHALL be legal at any occupancy; afull = occupancy>=threshold, combinational from registered count.
REQ-015 mem_rready_o SHALL be 0 outside MISS; memory beats arriving then remain stalled.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, cnt=0, both FIFOs empty, proto_err_o=0; hence inct_rvalid_o=0, inct_rlast_o=0, mem_rready_o=0, afull outputs 0.
REQ-017 Reset mid-burst SHALL discard the burst and all queued flags/lines; no beat is emitted after release until new pushes.

Configuration
REQ-018 Macro CC_REORDER_OUTREG_EN defined: inct outputs SHALL come from a 2-entry skid register (1 cycle added latency, full throughput, no combinational path mem_*_i/inct_rready_i to outputs); undefined: behaviour exactly REQ-007/008 combinational.

Verification (DATA_W=64, BURST_LEN=8)
REQ-019 Flags 0,1,0; line words 0x10..0x17, ofs 0; mem beats 0xA0..0xA7, 0xB0..0xB7 -> inct A0..A7, 10..17, B0..B7, rlast on each 8th beat.
REQ-020 Hit line ofs 5 -> inct order words 5,6,7,0,1,2,3,4; rlast with word 4.
REQ-021 inct_rready_i toggled 1,0,0,1 per cycle during HIT -> data held over stalls, 8 beats, no duplicates or losses.
REQ-022 mem_rlast_i asserted on beat 5 of a miss -> proto_err_o=1 from next cycle, stays 1; inct_rlast_o still on beat 7.
REQ-023 Push 4 flags -> flag_afull_o=1 at occupancy 2; fifth push ignored; rst_n low at beat 3 -> rvalid 0 immediately, FIFOs empty.
